// File: rtl/branch_predict_ctrl.sv
// Branch prediction and misprediction recovery controller.
// A table of 2-bit saturating counters predicts conditional branches in IF.
// Branches resolved in EX train the table. A misprediction issues a registered
// redirect plus IF/ID and ID/EX flushes, and the following bubble cycle is masked.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_stall,
  input  logic [31:0]      if_pc,
  input  logic             if_is_branch,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_fallthrough,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  logic [1:0]          table_q [ENTRIES];
  logic [1:0]          table_d [ENTRIES];
  logic [1:0]          state_q, state_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic                flush_q, flush_d;
  logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]    mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                resolve;
  logic                mispredict;
  logic                unused_pc_bits;

  // Halfword granularity so that compressed instructions get their own entries.
  assign if_idx = if_pc[IDX_BITS:1];
  assign ex_idx = ex_pc[IDX_BITS:1];
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+1], if_pc[0], ex_pc[31:IDX_BITS+1], ex_pc[0]};

  // Prediction reads registered table state only; a same-cycle update is not bypassed.
  assign pred_taken = if_is_branch & table_q[if_idx][1];

  // The bubble in EX during RECOVER, and anything while stalled, is never resolved.
  assign resolve    = ex_valid & ex_is_branch & (state_q == ST_RUN) & ~pipe_stall;
  assign mispredict = resolve & (ex_pred_taken != ex_taken);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      // Saturating counter update for this entry when the resolved branch maps here.
      always_comb begin
        table_d[gi] = table_q[gi];
        if (resolve && (ex_idx == IDX_BITS'(gi))) begin
          if (ex_taken) begin
            if (table_q[gi] != 2'b11) table_d[gi] = table_q[gi] + 2'b01;
          end else begin
            if (table_q[gi] != 2'b00) table_d[gi] = table_q[gi] - 2'b01;
          end
        end
      end

      // Entry register; resets to weakly not-taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) table_q[gi] <= 2'b01;
        else        table_q[gi] <= table_d[gi];
      end
    end
  endgenerate

  // Recovery sequencing: RUN -> FLUSH (one cycle of redirect/flush) -> RECOVER -> RUN.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    if (!pipe_stall) begin
      case (state_q)
        ST_RUN: begin
          if (mispredict) begin
            state_d          = ST_FLUSH;
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            redirect_pc_d    = ex_taken ? ex_target : ex_fallthrough;
          end
        end
        ST_FLUSH: begin
          state_d          = ST_RECOVER;
          redirect_valid_d = 1'b0;
          flush_d          = 1'b0;
        end
        ST_RECOVER: state_d = ST_RUN;
        default: begin
          state_d          = ST_RUN;
          redirect_valid_d = 1'b0;
          flush_d          = 1'b0;
        end
      endcase
    end
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolve && (branch_cnt_q != {CNT_W{1'b1}}))
      branch_cnt_d = branch_cnt_q + 1'b1;
    if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}}))
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
  end

  // Control and counter registers; reset aborts any flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_ifid     = flush_q;
  assign flush_idex     = flush_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_stall;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_fallthrough;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
    .if_pc(if_pc), .if_is_branch(if_is_branch), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_fallthrough(ex_fallthrough),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, v});
    chk({tag, ".fi"}, {31'd0, flush_ifid}, {31'd0, v});
    chk({tag, ".fx"}, {31'd0, flush_idex}, {31'd0, v});
    chk({tag, ".rpc"}, redirect_pc, pc);
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    if_is_branch = 1'b1;
    #1;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // Present one branch in EX for a single edge, then drop ex_valid.
  task automatic resolve_br(input logic [31:0] pc, input logic pred, input logic tk,
                            input logic [31:0] tgt, input logic [31:0] ft);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc;
    ex_pred_taken = pred; ex_taken = tk; ex_target = tgt; ex_fallthrough = ft;
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pipe_stall = 1'b0; if_pc = 32'h100; if_is_branch = 1'b0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 0; ex_pred_taken = 1'b0;
    ex_taken = 1'b0; ex_target = 0; ex_fallthrough = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Reset state
    chk_pred("rst.pred", 32'h100, 1'b0);
    chk_ctl("rst", 1'b0, 32'h0);
    chk("rst.bc", {16'd0, branch_cnt}, 32'd0);
    chk("rst.mc", {16'd0, mispredict_cnt}, 32'd0);

    // Mispredict taken: entry 0 01->10
    resolve_br(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    chk_ctl("mis", 1'b1, 32'h80);
    chk("mis.bc", {16'd0, branch_cnt}, 32'd1);
    chk("mis.mc", {16'd0, mispredict_cnt}, 32'd1);

    // FLUSH -> RECOVER: outputs drop after exactly one cycle
    step();
    chk("flush1.rv", {31'd0, redirect_valid}, 32'd0);
    chk("flush1.fi", {31'd0, flush_ifid}, 32'd0);

    // RECOVER: a mispredicting branch in EX is ignored
    resolve_br(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    chk("recov.rv", {31'd0, redirect_valid}, 32'd0);
    chk("recov.bc", {16'd0, branch_cnt}, 32'd1);
    chk("recov.mc", {16'd0, mispredict_cnt}, 32'd1);
    chk_pred("recov.pred", 32'h100, 1'b1);

    // Back in RUN: correct prediction counts, no redirect (entry 0 -> 11)
    resolve_br(32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
    chk("run.rv", {31'd0, redirect_valid}, 32'd0);
    chk("run.bc", {16'd0, branch_cnt}, 32'd2);
    chk("run.mc", {16'd0, mispredict_cnt}, 32'd1);

    // Three taken at 0x104 (entry 2: 01->10->11->11)
    for (int i = 0; i < 3; i++) resolve_br(32'h104, 1'b1, 1'b1, 32'h200, 32'h106);
    chk_pred("sat.pred", 32'h104, 1'b1);
    chk("sat.bc", {16'd0, branch_cnt}, 32'd5);

    // Not-taken with pred=1, compressed fallthrough (entry 2 -> 10)
    resolve_br(32'h104, 1'b1, 1'b0, 32'h200, 32'h106);
    chk_ctl("ft", 1'b1, 32'h106);
    chk("ft.mc", {16'd0, mispredict_cnt}, 32'd2);
    chk("ft.bc", {16'd0, branch_cnt}, 32'd6);
    chk_pred("ft.pred", 32'h104, 1'b1);
    step(); step();

    // Non-branch in EX never touches table or counters
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h104;
    ex_pred_taken = 1'b1; ex_taken = 1'b0;
    step();
    ex_valid = 1'b0;
    chk("nb.bc", {16'd0, branch_cnt}, 32'd6);
    chk("nb.rv", {31'd0, redirect_valid}, 32'd0);
    chk_pred("nb.pred", 32'h104, 1'b1);

    // Same-cycle read/write at entry 2 (10 -> 01): old value seen before the edge
    if_pc = 32'h104; if_is_branch = 1'b1;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h104;
    ex_pred_taken = 1'b0; ex_taken = 1'b0;
    #1;
    chk("rw.pred_old", {31'd0, pred_taken}, 32'd1);
    step();
    ex_valid = 1'b0;
    chk("rw.pred_new", {31'd0, pred_taken}, 32'd0);
    chk("rw.bc", {16'd0, branch_cnt}, 32'd7);

    // Stall while in FLUSH
    resolve_br(32'h108, 1'b1, 1'b0, 32'h300, 32'h10C);
    chk_ctl("stl.go", 1'b1, 32'h10C);
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctl($sformatf("stl.c%0d", i), 1'b1, 32'h10C);
    end
    pipe_stall = 1'b0;
    #1;
    chk_ctl("stl.rel", 1'b1, 32'h10C);
    step();
    chk("stl.end.rv", {31'd0, redirect_valid}, 32'd0);
    chk("stl.mc", {16'd0, mispredict_cnt}, 32'd3);
    step();

    // Async reset mid-FLUSH
    resolve_br(32'h100, 1'b0, 1'b1, 32'h80, 32'h104);
    chk_ctl("ar.go", 1'b1, 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("ar.clr", 1'b0, 32'h0);
    chk("ar.bc", {16'd0, branch_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    step(); step();
    chk_ctl("ar.post", 1'b0, 32'h0);
    chk_pred("ar.pred", 32'h100, 1'b0);
    // FSM back in RUN: a fresh mispredict is accepted immediately
    resolve_br(32'h100, 1'b1, 1'b0, 32'h80, 32'h104);
    chk_ctl("ar.run", 1'b1, 32'h104);
    chk("ar.mc", {16'd0, mispredict_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
